// File: rtl/data_mem_responder.sv
// Data-port responder for the pipelined processor: owns the word-addressed
// data RAM, takes a bulk image from the host before the run, serves
// zero-latency loads/stores while the processor runs, then streams a window
// of the RAM back to the host.
module data_mem_responder #(
    parameter int mbus       = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = 10,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    // processor data port
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    input  logic            MWE,
    input  logic            MRE,
    output logic [mbus-1:0] loadedData,
    output logic            cpu_run,
    // host load stream
    input  logic            load_valid,
    input  logic [mbus-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    // host dump stream
    input  logic            dump_req,
    output logic            dump_valid,
    output logic [mbus-1:0] dump_data,
    output logic            dump_last,
    input  logic            dump_ready,
    output logic            fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    localparam logic [mbus-1:0] DEPTH_W   = mbus'(DEPTH);
    localparam logic [AW-1:0]   LOAD_TOP  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   DUMP_FROM = AW'(DUMP_BASE);
    localparam logic [AW-1:0]   DUMP_END  = AW'(DUMP_BASE + DUMP_WORDS - 1);

    logic [mbus-1:0] mem [DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   load_ptr_q, load_ptr_d;
    logic [AW-1:0]   dump_ptr_q, dump_ptr_d;
    logic            cpu_run_q, cpu_run_d;
    logic            load_ready_q, load_ready_d;
    logic            dump_valid_q, dump_valid_d;
    logic            dump_last_q, dump_last_d;
    logic [mbus-1:0] dump_data_q, dump_data_d;
    logic            fault_q, fault_d;

    logic            load_we;
    logic            cpu_we;
    logic            in_range;
    logic [AW-1:0]   cpu_idx;
    logic            dump_hs;

    assign cpu_idx  = addressData[AW-1:0];
    assign in_range = (addressData < DEPTH_W);
    assign dump_hs  = dump_valid_q & dump_ready;

    // Processor read path: combinational, returns the pre-write word on a
    // same-cycle read+write because the RAM updates only at the edge.
    always_comb begin
        loadedData = '0;
        if (state_q == S_RUN && MRE && in_range)
            loadedData = mem[cpu_idx];
    end

    // Sequencer next-state, pointers, dump staging and fault accumulation.
    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        dump_ptr_d   = dump_ptr_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;
        dump_data_d  = dump_data_q;
        fault_d      = fault_q;
        load_we      = 1'b0;
        cpu_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // load takes priority over a simultaneous dump request
                if (load_valid) begin
                    state_d    = S_LOAD;
                    load_ptr_d = '0;
                end else if (dump_req) begin
                    state_d    = S_DUMP;
                    dump_ptr_d = DUMP_FROM;
                end
            end
            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    load_we = 1'b1;
                    if (load_last || load_ptr_q == LOAD_TOP) begin
                        // a full RAM without load_last ends the load; no wrap
                        state_d = S_RUN;
                        if (!load_last)
                            fault_d = 1'b1;
                    end else begin
                        load_ptr_d = load_ptr_q + AW'(1);
                    end
                end
            end
            S_RUN: begin
                if ((MRE || MWE) && !in_range)
                    fault_d = 1'b1;
                if (MWE && in_range)
                    cpu_we = 1'b1;
                if (dump_req) begin
                    state_d    = S_DUMP;
                    dump_ptr_d = DUMP_FROM;
                end
            end
            S_DUMP: begin
                if (dump_hs && dump_last_q) begin
                    state_d      = S_IDLE;
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                end else if (!dump_valid_q || dump_hs) begin
                    dump_data_d  = mem[dump_ptr_q];
                    dump_valid_d = 1'b1;
                    dump_last_d  = (dump_ptr_q == DUMP_END);
                    dump_ptr_d   = dump_ptr_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        cpu_run_d    = (state_d == S_RUN);
        load_ready_d = (state_d == S_LOAD);
    end

    // Control and output registers; reset aborts any in-flight transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_ptr_q   <= '0;
            dump_ptr_q   <= DUMP_FROM;
            cpu_run_q    <= 1'b0;
            load_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            dump_data_q  <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            dump_ptr_q   <= dump_ptr_d;
            cpu_run_q    <= cpu_run_d;
            load_ready_q <= load_ready_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            dump_data_q  <= dump_data_d;
            fault_q      <= fault_d;
        end
    end

    // RAM write port; contents survive reset, writes are gated off during it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_we)
                mem[load_ptr_q] <= load_data;
            else if (cpu_we)
                mem[cpu_idx] <= storeData;
        end
    end

    assign cpu_run    = cpu_run_q;
    assign load_ready = load_ready_q;
    assign dump_valid = dump_valid_q;
    assign dump_last  = dump_last_q;
    assign dump_data  = dump_data_q;
    assign fault      = fault_q;

endmodule
